eeg_sample_writer: RTL and testbench
====================================

// Module: eeg_sample_writer
// PURPOSE
// - Writer end of the EEG input buffer in intermediate-result memory (EEG_INPUT_MEM region).
// - Accepts 16b unsigned ADC samples over valid/ready and converts each to a double-width fixed-point word.
// - Writes the words sequentially into int-res memory. Patch projection later reads them back.
// - Active during the EEG_LOAD top-level state; asserts done when the full epoch is stored.
// PARAMETERS
// - NUM_SAMPLES  3840  samples per epoch (NUM_PATCHES*PATCH_LEN)
// - BASE_ADDR    0     int-res address of sample 0 (mem_map[EEG_INPUT_MEM])
// - ADDR_W       16    int-res address width (IntResAddr_t)
// - DATA_W       30    double-width word (2*N_STO_INT_RES)
// - FRAC_SHIFT   10    left shift applied to the sample inside the Q(DATA_W-20).20 word
// PORTS
// - clk              in   1        system clock
// - rst              in   1        synchronous, active-high reset
// - start_eeg_load   in   1        1-cycle pulse: begin loading one epoch
// - adc_data         in   16       AdcData_t sample
// - adc_valid        in   1        adc_data valid
// - adc_ready        out  1        block accepts sample this cycle
// - mem_gnt          in   1        memory accepts the presented write this cycle
// - wr_en            out  1        write request
// - wr_addr          out  ADDR_W   write address
// - wr_data          out  DATA_W   write data (IntResDouble_t)
// - wr_width         out  1        DataWidth_t; always DOUBLE_WIDTH
// - busy             out  1        high in LOAD and DRAIN
// - done             out  1        1-cycle pulse after the last write is granted
// - samples_written  out  12       count of granted writes in the current epoch
// BEHAVIOUR
// - Clock and reset: single clock clk; synchronous active-high rst.
// - Reset values: state=IDLE, adc_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, busy=0, done=0, counters=0.
//   wr_width is a constant DOUBLE_WIDTH.
// - FSM states: IDLE, LOAD, DRAIN, DONE.
//   - IDLE -> LOAD on start_eeg_load; both counters are cleared.
//   - LOAD -> DRAIN when the NUM_SAMPLES-th sample is accepted.
//   - DRAIN -> DONE when the final write is granted.
//   - DONE -> IDLE after 1 cycle; done=1 only in DONE.
// - start_eeg_load outside IDLE is ignored.
// - Sample handshake:
//   - Transfer occurs when adc_valid & adc_ready.
//   - adc_ready = (state==LOAD) & (!wr_en | mem_gnt). This is a 1-entry output register with a combinational bypass on grant.
//   - adc_ready is never high in IDLE, DRAIN or DONE. Samples offered then are not consumed.
// - Write port:
//   - A sample accepted in cycle N is presented (wr_en=1) in cycle N+1. Latency is 1 cycle.
//   - wr_addr, wr_data and wr_en hold stable until mem_gnt.
//   - Grant and new accept in the same cycle reload the register with no bubble. Throughput is 1 sample/cycle with mem_gnt tied high.
// - Addressing:
//   - wr_addr = BASE_ADDR + accepted index, from a separate acc_cnt.
//   - samples_written increments on wr_en & mem_gnt.
//   - No wrap: acc_cnt saturates at NUM_SAMPLES because adc_ready drops.
// - Conversion (default):
//   - wr_data = {(DATA_W-16-FRAC_SHIFT)'b0, adc_data, FRAC_SHIFT'b0}.
//   - This is always non-negative. Value = adc_data / 2^FRAC_SHIFT in Q20.
// - Reset mid-operation:
//   - The pending write is dropped (wr_en=0 next cycle) and the block returns to IDLE.
//   - Partial memory contents are not cleared.
// CONFIGURATION
// - Macro EEG_MIDSCALE_REMOVE_EN.
// - Defined:
//   - The sample is made signed by inverting bit 15 (adc_data - 2^15).
//   - It is then sign-extended: wr_data = {{(DATA_W-16-FRAC_SHIFT){s[15]}}, s, FRAC_SHIFT'b0}, with s = adc_data ^ 16'h8000.
//   - Range is +/-32 in Q20.
// - Undefined: the unsigned zero-extension above. There is no other difference.
// TESTING
// - Reset: assert rst mid-LOAD after 100 samples -> next cycle wr_en=0, busy=0, state IDLE; a new start begins again at BASE_ADDR.
// - Streaming: start, mem_gnt=1, adc_valid=1 for 3840 cycles.
//   -> 3840 writes to addresses 0..3839, with no bubbles;
//   -> done pulses exactly once, 2 cycles after the last accept;
//   -> samples_written=3840.
// - Backpressure: mem_gnt=0 for cycles 5-9.
//   -> adc_ready=0 in those cycles; wr_addr/wr_data stable;
//   -> no sample lost or duplicated; the write at address 4 is granted on cycle 10.
// - Conversion (default): adc_data=16'hFFFF -> wr_data=30'h03FFFC00; adc_data=16'h0001 -> 30'h00000400.
// - Conversion (EEG_MIDSCALE_REMOVE_EN): 16'h0000 -> 30'h3E000000; 16'h8000 -> 30'h0; 16'hFFFF -> 30'h01FFFC00.
// - Protocol: start pulsed again during LOAD is ignored.
//   -> Samples with adc_valid=1 in IDLE or DONE are not consumed (adc_ready=0).
//   -> A 3841st sample remains pending.

Source files
------------

// File: rtl/eeg_sample_writer_if.sv
// Sample-in / memory-write bus of the EEG input buffer writer.
// master: writer side (adc_ready, wr_* out); slave: ADC + memory side.
interface eeg_sample_writer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 30
);
    logic [15:0]       adc_data;
    logic              adc_valid;
    logic              adc_ready;
    logic              mem_gnt;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_width;

    modport master (
        input  adc_data, adc_valid, mem_gnt,
        output adc_ready, wr_en, wr_addr,
        output wr_data, wr_width
    );

    modport slave (
        output adc_data, adc_valid, mem_gnt,
        input  adc_ready, wr_en, wr_addr,
        input  wr_data, wr_width
    );
endinterface

// File: rtl/eeg_sample_writer.sv
// EEG epoch writer: ADC samples -> fixed-point words -> int-res memory.
// Ports: clk, rst (sync, active-high), start_eeg_load pulse,
//   bus (adc_data/valid/ready in, wr_en/addr/data/width out, mem_gnt),
//   busy, done pulse, samples_written (granted writes this epoch).
// Option: EEG_MIDSCALE_REMOVE_EN stores adc_data - 2^15, sign-extended.
module eeg_sample_writer #(
    parameter int NUM_SAMPLES = 3840,
    parameter int BASE_ADDR   = 0,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 30,
    parameter int FRAC_SHIFT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_eeg_load,
    eeg_sample_writer_if.master bus,
    output logic        busy,
    output logic        done,
    output logic [11:0] samples_written
);
    localparam int PAD = DATA_W - 16 - FRAC_SHIFT;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic DOUBLE_WIDTH = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [11:0]       acc_cnt_q, acc_cnt_d;
    logic [11:0]       wr_cnt_q, wr_cnt_d;

    logic              accept;
    logic              grant;
    logic              last_acc;
    logic [DATA_W-1:0] conv;

`ifdef EEG_MIDSCALE_REMOVE_EN
    logic [15:0] s;
    assign s    = bus.adc_data ^ 16'h8000;
    assign conv = {{PAD{s[15]}}, s,
                   {FRAC_SHIFT{1'b0}}};
`else
    assign conv = {{PAD{1'b0}}, bus.adc_data,
                   {FRAC_SHIFT{1'b0}}};
`endif

    // Output register frees up on grant, so a new
    // sample may be taken in the same cycle.
    assign bus.adc_ready = (state_q == LOAD) &
                           (!wr_en_q | bus.mem_gnt);
    assign accept   = bus.adc_valid & bus.adc_ready;
    assign grant    = wr_en_q & bus.mem_gnt;
    assign last_acc = acc_cnt_q ==
                      12'(NUM_SAMPLES - 1);

    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_eeg_load) begin
                    state_d   = LOAD;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            LOAD: begin
                if (accept && last_acc)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (grant)
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (grant) begin
            wr_en_d  = 1'b0;
            wr_cnt_d = wr_cnt_q + 12'd1;
        end
        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ADDR_W'(BASE_ADDR) +
                        ADDR_W'(acc_cnt_q);
            wr_data_d = conv;
            acc_cnt_d = acc_cnt_q + 12'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= ADDR_W'(BASE_ADDR);
            wr_data_q <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wr_width = DOUBLE_WIDTH;

    assign busy = (state_q == LOAD) |
                  (state_q == DRAIN);
    assign done = state_q == DONE;
    assign samples_written = wr_cnt_q;
endmodule

// File: tb/tb_eeg_sample_writer.sv
// Directed bench for eeg_sample_writer: reset, backpressure,
// streaming, conversion, protocol and mid-load reset.
module tb_eeg_sample_writer;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [11:0] sw;

    logic        src_clr;
    logic        wr_clr;
    int          src_idx = 0;
    int          wr_idx  = 0;
    int          bad     = 0;
    int          done_cnt = 0;

    int checks   = 0;
    int failures = 0;

    eeg_sample_writer_if #(.ADDR_W(16), .DATA_W(30)) bus ();

    eeg_sample_writer dut (
        .clk             (clk),
        .rst             (rst),
        .start_eeg_load  (start),
        .bus             (bus),
        .busy            (busy),
        .done            (done),
        .samples_written (sw)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(int i);
        case (i)
            0:       pat = 16'hFFFF;
            1:       pat = 16'h0001;
            2:       pat = 16'h0000;
            3:       pat = 16'h8000;
            default: pat = 16'(i * 40503 + 7);
        endcase
    endfunction

    // Reference conversion as arithmetic (x * 2^10).
    function automatic logic [29:0] ref_conv(logic [15:0] x);
`ifdef EEG_MIDSCALE_REMOVE_EN
        ref_conv = 30'((int'(x) - 32768) * 1024);
`else
        ref_conv = 30'(int'(x) * 1024);
`endif
    endfunction

    // Hand-computed words for pat(0..3).
    function automatic logic [29:0] hand(int i);
`ifdef EEG_MIDSCALE_REMOVE_EN
        case (i)
            0:       hand = 30'h01FFFC00;
            1:       hand = 30'h3E000400;
            2:       hand = 30'h3E000000;
            default: hand = 30'h00000000;
        endcase
`else
        case (i)
            0:       hand = 30'h03FFFC00;
            1:       hand = 30'h00000400;
            2:       hand = 30'h00000000;
            default: hand = 30'h02000000;
        endcase
`endif
    endfunction

    assign bus.adc_data = pat(src_idx);

    always @(posedge clk) begin
        if (src_clr)
            src_idx <= 0;
        else if (bus.adc_valid && bus.adc_ready)
            src_idx <= src_idx + 1;
    end

    always @(posedge clk) begin
        if (wr_clr) begin
            wr_idx   <= 0;
            done_cnt <= 0;
        end else begin
            if (bus.wr_en && bus.mem_gnt) begin
                if (bus.wr_addr != 16'(wr_idx) ||
                    bus.wr_data != ref_conv(pat(wr_idx)))
                    bad <= bad + 1;
                wr_idx <= wr_idx + 1;
            end
            if (done)
                done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_tb();
        src_clr = 1'b1;
        wr_clr  = 1'b1;
        tick();
        src_clr = 1'b0;
        wr_clr  = 1'b0;
    endtask

    int k;
    int done_k;
    int stall_bad;
    int bubbles;
    bit seen;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        src_clr = 1'b1;
        wr_clr = 1'b1;
        bus.adc_valid = 1'b0;
        bus.mem_gnt = 1'b0;
        repeat (3) tick();

        chk("rst_ready", 32'(bus.adc_ready), 0);
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_addr", 32'(bus.wr_addr), 0);
        chk("rst_data", 32'(bus.wr_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sw", 32'(sw), 0);
        chk("wr_width", 32'(bus.wr_width), 1);

        rst = 1'b0;
        src_clr = 1'b0;
        wr_clr = 1'b0;
        bus.adc_valid = 1'b1;
        repeat (3) tick();
        chk("idle_ready", 32'(bus.adc_ready), 0);
        chk("idle_src", 32'(src_idx), 0);

        // Backpressure epoch, start re-pulsed in LOAD.
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        seen = 0;
        done_k = -1;
        stall_bad = 0;
        while (!seen && k < 6000) begin
            bus.mem_gnt = !(k >= 5 && k <= 9);
            start = (k == 20);
            #1;
            if (k == 0)
                chk("bp_ready0", 32'(bus.adc_ready), 1);
            if (k >= 5 && k <= 9) begin
                if (bus.adc_ready || !bus.wr_en ||
                    bus.wr_addr != 16'd4 ||
                    bus.wr_data != ref_conv(pat(4)))
                    stall_bad++;
            end
            if (k == 10) begin
                chk("bp_g4_en", 32'(bus.wr_en), 1);
                chk("bp_g4_addr", 32'(bus.wr_addr), 4);
            end
            if (k == 21) begin
                chk("bp_restart_sw", 32'(sw), 15);
                chk("bp_restart_addr",
                    32'(bus.wr_addr), 15);
            end
            if (done) begin
                seen = 1;
                done_k = k;
                chk("bp_sw", 32'(sw), 3840);
            end
            tick();
            k++;
        end
        start = 1'b0;
        chk("bp_done_seen", 32'(seen), 1);
        chk("bp_stall", 32'(stall_bad), 0);
        chk("bp_done_k", 32'(done_k), 3846);
        repeat (3) tick();
        chk("bp_done_cnt", 32'(done_cnt), 1);
        chk("bp_pending", 32'(src_idx), 3840);
        chk("bp_writes", 32'(wr_idx), 3840);
        chk("bp_idle_rdy", 32'(bus.adc_ready), 0);
        chk("bp_idle_busy", 32'(busy), 0);

        // Full-rate streaming epoch.
        clear_tb();
        bus.mem_gnt = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        seen = 0;
        done_k = -1;
        bubbles = 0;
        while (!seen && k < 6000) begin
            #1;
            if (k >= 1 && k <= 3840 && !bus.wr_en)
                bubbles++;
            if (k >= 1 && k <= 4)
                chk($sformatf("conv%0d", k - 1),
                    32'(bus.wr_data), 32'(hand(k - 1)));
            if (k == 1)
                chk("st_addr0", 32'(bus.wr_addr), 0);
            if (k == 3840)
                chk("st_addr_last",
                    32'(bus.wr_addr), 3839);
            if (done) begin
                seen = 1;
                done_k = k;
                chk("st_sw", 32'(sw), 3840);
            end
            tick();
            k++;
        end
        chk("st_done_seen", 32'(seen), 1);
        chk("st_done_k", 32'(done_k), 3841);
        chk("st_bubbles", 32'(bubbles), 0);
        tick();
        chk("st_done_cnt", 32'(done_cnt), 1);
        chk("st_writes", 32'(wr_idx), 3840);

        // Reset after 100 samples, then restart.
        clear_tb();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("mr_addr99", 32'(bus.wr_addr), 99);
        rst = 1'b1;
        tick();
        chk("mr_wr_en", 32'(bus.wr_en), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ready", 32'(bus.adc_ready), 0);
        chk("mr_sw", 32'(sw), 0);
        rst = 1'b0;
        tick();
        clear_tb();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mr_re_addr", 32'(bus.wr_addr), 0);
        chk("mr_re_data", 32'(bus.wr_data),
            32'(hand(0)));
        chk("mr_re_busy", 32'(busy), 1);
        tick();
        chk("wr_seq_bad", 32'(bad), 0);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end
endmodule
